// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: fetch state encoding, NOP encoding, reset PC
// and the word-alignment helper used by the fetch unit.
package rv32_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_WAIT  = 2'd1,
      FETCH_FLUSH = 2'd2,
      FETCH_FAULT = 2'd3
   } fetch_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_timer.sv
// 8-bit fetch timeout counter; expire flags the cycle whose increment would reach LIMIT.
module fetch_timer #(
   parameter logic [7:0] LIMIT = 8'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [7:0] count;

   // NOTE: non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   assign expire = enable && (count == LIMIT - 8'd1);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word read per fetch_req, handles redirects
// while a read is outstanding, and faults if memory never acknowledges.
module instr_fetch
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] old_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        fault
);

   fetch_state_t state;
   logic [31:0]  target;
   logic [31:0]  next_addr;
   logic         waiting;
   logic         timeout;

   assign target    = word_align(pc_target);
   assign next_addr = pc_load ? target : pc;
   assign waiting   = (state == FETCH_WAIT) || (state == FETCH_FLUSH);
   assign busy      = (state != FETCH_IDLE);

   // Counter restarts every time the unit sits in IDLE, so each request gets a full budget.
   fetch_timer #(
      .LIMIT (TIMEOUT_CYCLES[7:0])
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == FETCH_IDLE),
      .enable (waiting && !mem_ack),
      .expire (timeout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= FETCH_IDLE;
         pc          <= RESET_PC;
         old_pc      <= 32'd0;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= 32'd0;
         fault       <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         unique case (state)
            FETCH_IDLE: begin
               if (fetch_req) begin
                  mem_req  <= 1'b1;
                  mem_addr <= next_addr;
                  pc       <= next_addr;
                  state    <= FETCH_WAIT;
               end else if (pc_load) begin
                  pc <= target;
               end
            end

            FETCH_WAIT, FETCH_FLUSH: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= FETCH_IDLE;
                  // A redirect seen now or earlier makes the returning word stale.
                  if (pc_load) begin
                     pc <= target;
                  end else if (state == FETCH_WAIT) begin
                     instr       <= mem_rdata;
                     old_pc      <= mem_addr;
                     pc          <= mem_addr + 32'd4;
                     instr_valid <= 1'b1;
                  end
               end else if (timeout) begin
                  mem_req <= 1'b0;
                  fault   <= 1'b1;
                  state   <= FETCH_FAULT;
                  if (pc_load) pc <= target;
               end else if (pc_load) begin
                  pc    <= target;
                  state <= FETCH_FLUSH;
               end
            end

            FETCH_FAULT: begin
               if (pc_load) begin
                  fault <= 1'b0;
                  pc    <= target;
                  state <= FETCH_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: stimulus predicts delivered words,
// a monitor compares them whenever instr_valid pulses.
module tb_instr_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] MASK = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic        pc_load = 1'b0;
   logic [31:0] pc_target = 32'd0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] old_pc;
   logic        instr_valid;
   logic        busy;
   logic        fault;

   instr_fetch #(
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .pc          (pc),
      .old_pc      (old_pc),
      .instr_valid (instr_valid),
      .busy        (busy),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] old_pc;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          compared = 0;
   int          mismatched = 0;
   logic [31:0] m_pc, m_instr, m_old_pc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every delivered instruction must match the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && instr_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_instr_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_instr", instr, e.instr);
               check("sb_old_pc", old_pc, e.old_pc);
               check("sb_pc", pc, e.pc);
            end
         end
      end
   end

   task automatic model_reset();
      sb.delete();
      m_pc     = 32'd0;
      m_instr  = NOP;
      m_old_pc = 32'd0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      fetch_req = 1'b0;
      pc_load = 1'b0;
      mem_ack = 1'b0;
      tick();
      tick();
      model_reset();
      rst = 1'b1;
      tick();
   endtask

   // One fetch: lat stall cycles then an ack; redirects may land on any cycle
   // from the first WAIT cycle through the ack cycle.
   task automatic fetch(input int lat, input logic [31:0] data, input bit load_req,
                        input logic [31:0] req_tgt, input int redir_at,
                        input logic [31:0] redir_tgt, input int p_redir);
      logic [31:0] addr;
      bit          discard;
      bit          ld;
      discard = 1'b0;
      addr = load_req ? (req_tgt & MASK) : m_pc;
      fetch_req = 1'b1;
      pc_load   = load_req;
      pc_target = req_tgt;
      tick();
      fetch_req = 1'b0;
      pc_load   = 1'b0;
      m_pc = addr;
      check("req_issued", mem_req, 32'd1);
      check("req_addr", mem_addr, addr);
      check("busy_wait", busy, 32'd1);
      for (int i = 0; i <= lat; i++) begin
         ld = (i == redir_at) || ($urandom_range(99) < p_redir);
         fetch_req = ($urandom_range(3) == 0);
         pc_load   = ld;
         pc_target = (i == redir_at) ? redir_tgt : $urandom;
         mem_ack   = (i == lat);
         mem_rdata = (i == lat) ? data : $urandom;
         if (ld) begin
            discard = 1'b1;
            m_pc = pc_target & MASK;
         end
         if (i == lat && !discard) begin
            m_instr  = data;
            m_old_pc = addr;
            m_pc     = addr + 32'd4;
            sb.push_back('{instr: data, old_pc: addr, pc: addr + 32'd4});
         end
         tick();
         if (i < lat) begin
            check("req_held", mem_req, 32'd1);
            check("addr_held", mem_addr, addr);
         end
      end
      mem_ack = 1'b0;
      pc_load = 1'b0;
      fetch_req = 1'b0;
      check("valid_pulse", instr_valid, {31'd0, !discard});
      check("req_dropped", mem_req, 32'd0);
      check("pc_after", pc, m_pc);
      check("instr_after", instr, m_instr);
      check("old_pc_after", old_pc, m_old_pc);
      check("busy_idle", busy, 32'd0);
   endtask

   // Idle cycles with spurious acks, which must be ignored.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         mem_ack   = $urandom_range(1);
         mem_rdata = $urandom;
         tick();
         check("idle_no_valid", instr_valid, 32'd0);
         check("idle_no_req", mem_req, 32'd0);
      end
      mem_ack = 1'b0;
   endtask

   task automatic idle_load(input logic [31:0] tgt);
      pc_load = 1'b1;
      pc_target = tgt;
      tick();
      pc_load = 1'b0;
      m_pc = tgt & MASK;
      check("load_pc", pc, m_pc);
      check("load_no_req", mem_req, 32'd0);
      check("load_instr_kept", instr, m_instr);
      check("load_busy", busy, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;
      model_reset();
      do_reset();
      check("rst_pc", pc, 32'd0);
      check("rst_old_pc", old_pc, 32'd0);
      check("rst_instr", instr, NOP);
      check("rst_valid", instr_valid, 32'd0);
      check("rst_mem_req", mem_req, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_fault", fault, 32'd0);
      check("rst_busy", busy, 32'd0);

      // Three stall cycles then a known word.
      fetch(3, 32'h0050_0093, 1'b0, 32'd0, -1, 32'd0, 0);
      check("basic_instr", instr, 32'h0050_0093);
      check("basic_old_pc", old_pc, 32'd0);
      check("basic_pc", pc, 32'd4);
      idle(1);

      // Zero-wait back-to-back fetches from reset.
      do_reset();
      for (int k = 0; k < 3; k++) fetch(0, $urandom, 1'b0, 32'd0, -1, 32'd0, 0);
      check("b2b_old_pc", old_pc, 32'd8);

      // Redirect while waiting discards the returning word.
      fetch(2, 32'hDEAD_BEEF, 1'b0, 32'd0, 0, 32'h0000_0103, 0);
      check("flush_pc", pc, 32'h0000_0100);
      fetch(1, $urandom, 1'b0, 32'd0, -1, 32'd0, 0);

      // Timeout into FAULT, then recovery by pc_load.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      cycles = 0;
      while (mem_req === 1'b1 && cycles < 300) begin
         cycles++;
         fetch_req = $urandom_range(1);
         tick();
      end
      fetch_req = 1'b0;
      check("timeout_cycles", cycles, 32'd255);
      check("fault_set", fault, 32'd1);
      check("fault_req", mem_req, 32'd0);
      check("fault_busy", busy, 32'd1);
      fetch_req = 1'b1;
      mem_ack = 1'b1;
      tick();
      fetch_req = 1'b0;
      mem_ack = 1'b0;
      check("fault_ignore_req", mem_req, 32'd0);
      check("fault_sticky", fault, 32'd1);
      check("fault_no_valid", instr_valid, 32'd0);
      idle_load(32'h0000_0040);
      check("fault_cleared", fault, 32'd0);

      // PC wrap at the top of the address space.
      idle_load(32'hFFFF_FFFC);
      fetch(1, 32'h1234_5677, 1'b0, 32'd0, -1, 32'd0, 0);
      check("wrap_pc", pc, 32'd0);

      // Asynchronous reset in the middle of WAIT, then a late ack.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      #3 rst = 1'b0;
      #1;
      check("arst_mem_req", mem_req, 32'd0);
      check("arst_instr", instr, NOP);
      check("arst_busy", busy, 32'd0);
      check("arst_pc", pc, 32'd0);
      model_reset();
      #2 rst = 1'b1;
      tick();
      mem_ack = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      tick();
      mem_ack = 1'b0;
      check("late_ack_valid", instr_valid, 32'd0);
      check("late_ack_req", mem_req, 32'd0);
      check("late_ack_instr", instr, NOP);
      fetch(0, $urandom, 1'b0, 32'd0, -1, 32'd0, 0);

      // Randomized mix of fetches, redirects and idle traffic.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(9);
         if (r < 2) idle_load($urandom);
         else if (r < 4) idle($urandom_range(3, 1));
         else fetch($urandom_range(5), $urandom, ($urandom_range(4) == 0), $urandom, -1, 32'd0, 15);
      end
      idle(2);
      check("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255 (8-bit range 1..255): max cycles waiting for mem_ack before fault.
REQ-003 clk  input  1  rising-edge clock, sole clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fetch_req  input  1  control unit requests next instruction.
REQ-006 pc_load  input  1  redirect; load PC from pc_target.
REQ-007 pc_target  input  32  branch/jump target address.
REQ-008 mem_req  output  1  memory read request.
REQ-009 mem_addr  output  32  read address, word-aligned.
REQ-010 mem_ack  input  1  read data valid this cycle.
REQ-011 mem_rdata  input  32  read data.
REQ-012 instr  output  32  current instruction word, feeds immediate extender and decoder.
REQ-013 pc  output  32  next fetch address.
REQ-014 old_pc  output  32  address of instr.
REQ-015 instr_valid  output  1  one-cycle pulse: instr/old_pc updated.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 fault  output  1  fetch timeout flag, sticky.

Function
REQ-018 States: IDLE, WAIT, FLUSH, FAULT; all outputs registered except busy (decoded from state).
REQ-019 IDLE + fetch_req: next cycle mem_req=1, mem_addr=pc, state WAIT, timeout counter cleared.
REQ-020 IDLE + fetch_req + pc_load same cycle: mem_addr=pc_target with bits[1:0] forced 0, pc=that address.
REQ-021 IDLE + pc_load alone: pc={pc_target[31:2],2'b00}; no request issued; instr unchanged.
REQ-022 WAIT/FLUSH: mem_req held 1 and mem_addr held stable until mem_ack; request never withdrawn except by timeout or reset.
REQ-023 WAIT + mem_ack: same edge instr=mem_rdata, old_pc=mem_addr, pc=mem_addr+4 (mod 2^32, 32'hFFFFFFFC wraps to 0), instr_valid=1 for one cycle, mem_req=0, state IDLE.
REQ-024 Zero-wait memory: ack in first WAIT cycle gives instr_valid two cycles after fetch_req.
REQ-025 WAIT + pc_load (no ack): pc=aligned pc_target, state FLUSH.
REQ-026 FLUSH + mem_ack, or WAIT + mem_ack + pc_load same cycle: data discarded, instr/old_pc unchanged, instr_valid=0, pc=latest target, state IDLE.
REQ-027 fetch_req ignored outside IDLE; pc_load in FLUSH overwrites pc again.
REQ-028 Timeout counter increments each WAIT/FLUSH cycle without ack; reaching TIMEOUT_CYCLES: mem_req=0, fault=1, state FAULT.
REQ-029 FAULT: fetch_req ignored; pc_load clears fault, loads pc, state IDLE.
REQ-030 mem_ack in IDLE or FAULT ignored.

Reset
REQ-031 rst low asynchronously: state IDLE, pc=RESET_PC, old_pc=0, instr=32'h00000013 (NOP), instr_valid=0, mem_req=0, mem_addr=0, fault=0, counter=0.
REQ-032 Reset mid-WAIT drops mem_req immediately; a late mem_ack after release is ignored (IDLE).
REQ-033 First fetch_req after rst deassert fetches RESET_PC.

Structure
REQ-034 Shared package rv32_pkg holds the fetch state encoding, NOP constant 32'h00000013, and default RESET_PC.
REQ-035 One sub-module fetch_timer: 8-bit counter with clear, enable, terminal-count output.

Verification
REQ-036 Reset, fetch_req, ack after 3 cycles with 32'h00500093 -> instr=32'h00500093, old_pc=0, pc=4, one instr_valid pulse.
REQ-037 Zero-wait ack -> instr_valid two cycles after fetch_req; back-to-back fetches give old_pc 0,4,8.
REQ-038 pc_load 32'h00000103 during WAIT, then ack 32'hDEADBEEF -> instr stays previous, no pulse, pc=32'h00000100; next fetch addr 32'h00000100.
REQ-039 No ack for 255 cycles -> fault=1, mem_req=0; pc_load 32'h40 -> fault=0, busy=0, pc=32'h40.
REQ-040 pc=32'hFFFFFFFC fetch + ack -> pc=0; async rst mid-WAIT -> mem_req=0 without clock edge, instr=32'h00000013.
